// File: rtl/adder_seq_arb.sv
// rtl/adder_seq_arb.sv - two-requester round-robin adder that walks W-bit operands
// through one shared external 4-bit full-adder slice, one nibble per cycle.
module adder_seq_arb #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [4*NIBBLES-1:0]   req0_a,
   input  logic [4*NIBBLES-1:0]   req0_b,
   input  logic                   req0_cin,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [4*NIBBLES-1:0]   req1_a,
   input  logic [4*NIBBLES-1:0]   req1_b,
   input  logic                   req1_cin,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_id,
   output logic [4*NIBBLES-1:0]   rsp_sum,
   output logic                   rsp_cout,
   output logic [3:0]             add_a,
   output logic [3:0]             add_b,
   output logic                   add_cin,
   input  logic [3:0]             add_sum,
   input  logic                   add_cout
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [3:0] LAST_IDX = 4'(NIBBLES - 1);

   state_t                 state, state_next;
   logic                   last_grant;
   logic [3:0]             idx;
   logic                   carry;
   logic                   id;
   logic [4*NIBBLES-1:0]   a_q, b_q, sum_q;
   logic                   accept;

   assign accept   = req0_ready | req1_ready;
   assign rsp_sum  = sum_q;
   assign rsp_cout = carry;
   assign rsp_id   = id;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Readies are gated by rst_n so nothing is offered while reset is asserted.
   always_comb begin
      state_next = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp_valid  = 1'b0;
      add_a      = 4'd0;
      add_b      = 4'd0;
      add_cin    = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = rst_n && req0_valid && (!req1_valid || last_grant);
            req1_ready = rst_n && req1_valid && (!req0_valid || !last_grant);
            if (req0_ready || req1_ready) state_next = RUN;
         end
         RUN: begin
            for (int n = 0; n < NIBBLES; n++) begin
               if (idx == 4'(n)) begin
                  add_a = a_q[4*n +: 4];
                  add_b = b_q[4*n +: 4];
               end
            end
            add_cin = carry;
            if (idx == LAST_IDX) state_next = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         idx        <= 4'd0;
         carry      <= 1'b0;
         id         <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
      end else if (accept) begin
         a_q        <= req1_ready ? req1_a   : req0_a;
         b_q        <= req1_ready ? req1_b   : req0_b;
         carry      <= req1_ready ? req1_cin : req0_cin;
         id         <= req1_ready;
         last_grant <= req1_ready;
         idx        <= 4'd0;
         sum_q      <= '0;
      end else if (state == RUN) begin
         for (int n = 0; n < NIBBLES; n++) begin
            if (idx == 4'(n)) sum_q[4*n +: 4] <= add_sum;
         end
         carry <= add_cout;
         idx   <= idx + 4'd1;
      end
   end

endmodule
